// File: rtl/adc_capture_if.sv
// Sample-path signals of the serial-ADC front end: the 3-wire ADC pins plus the sample output.
// pushADC is a one-cycle valid with no ready (the consumer must always accept); data holds until the next strobe.
interface adc_capture_if;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_sdo;
  logic        pushADC;
  logic [25:0] data;

  modport master (output adc_cs_n, output adc_sclk, input adc_sdo, output pushADC, output data);
  modport slave  (input adc_cs_n, input adc_sclk, output adc_sdo, input pushADC, input data);
endinterface

// File: rtl/adc_capture.sv
// Serial-ADC capture: timer-paced conversions over cs_n/sclk/sdo, MSB first,
// emitted as a sign-extended 26-bit sample with a one-cycle pushADC strobe.
module adc_capture #(
  parameter int ADC_BITS      = 14,
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 128,
  parameter int OFFSET_BINARY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr_ovr,
  adc_capture_if.master bus,
  output logic       busy,
  output logic       overrun,
  output logic [1:0] dbg_state
);
  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(ADC_BITS + 1);
  localparam logic [ADC_BITS-1:0] MSB_FLIP =
    (OFFSET_BINARY != 0) ? (ADC_BITS'(1) << (ADC_BITS - 1)) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q;
  logic                tick;
  logic [DW-1:0]       div_q, div_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [ADC_BITS-1:0] shreg_q, shreg_d, word;
  logic                cs_n_q, cs_n_d, sclk_q, sclk_d, push_q, push_d;
  logic                busy_q, ovr_q, ovr_d, div_end;
  logic [25:0]         data_q, data_d;

  assign tick    = en && (timer_q == TW'(SAMPLE_PERIOD - 1));
  assign div_end = (div_q == DW'(CLK_DIV - 1));
  assign word    = shreg_q ^ MSB_FLIP;

  always_ff @(posedge clk) begin
    if (rst || !en || tick) timer_q <= '0;
    else                    timer_q <= timer_q + TW'(1);
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    push_d  = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: if (tick) begin
        state_d = SETUP;
        cs_n_d  = 1'b0;
        sclk_d  = 1'b1;
        div_d   = '0;
      end
      SETUP: if (div_end) begin
        state_d = SHIFT;
        sclk_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
      end else begin
        div_d = div_q + DW'(1);
      end
      SHIFT: if (!div_end) begin
        div_d = div_q + DW'(1);
      end else begin
        div_d = '0;
        // sdo is captured on the same edge that raises sclk
        if (!sclk_q) begin
          sclk_d  = 1'b1;
          shreg_d = {shreg_q[ADC_BITS-2:0], bus.adc_sdo};
        end else if (bit_q == BW'(ADC_BITS - 1)) begin
          state_d = DONE;
          cs_n_d  = 1'b1;
          push_d  = 1'b1;
          data_d  = 26'($signed(word));
        end else begin
          bit_d  = bit_q + BW'(1);
          sclk_d = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ovr_d = ovr_q;
    if (clr_ovr) ovr_d = 1'b0;
    if (tick && (state_q != IDLE)) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      push_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      push_q  <= push_d;
      data_q  <= data_d;
      busy_q  <= (state_d != IDLE);
      ovr_q   <= ovr_d;
    end
  end

  assign bus.adc_cs_n = cs_n_q;
  assign bus.adc_sclk = sclk_q;
  assign bus.pushADC  = push_q;
  assign bus.data     = data_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: two lanes (defaults/offset-binary, and 64-cycle period/two's complement)
// with a behavioural ADC, a frame-window reference model and a push scoreboard.
module tb_adc_capture;
  localparam int N_BITS = 14;
  localparam int DIV    = 4;
  localparam int FRAME  = 1 + DIV * (1 + 2 * N_BITS);
  localparam int PER0   = 128;
  localparam int PER1   = 64;

  typedef struct packed {
    logic [31:0] t;
    logic [25:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic clr_ovr = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]       cs_n_v, sclk_v, push_v, busy_v, ovr_v;
  logic [1:0]       sdo_v = 2'b00;
  logic [1:0][25:0] data_v;
  logic [1:0][1:0]  dbg_v;

  adc_capture_if bus_a ();
  adc_capture_if bus_b ();

  adc_capture #(.ADC_BITS(N_BITS), .CLK_DIV(DIV), .SAMPLE_PERIOD(PER0), .OFFSET_BINARY(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .clr_ovr(clr_ovr), .bus(bus_a),
    .busy(busy_v[0]), .overrun(ovr_v[0]), .dbg_state(dbg_v[0]));

  adc_capture #(.ADC_BITS(N_BITS), .CLK_DIV(DIV), .SAMPLE_PERIOD(PER1), .OFFSET_BINARY(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .clr_ovr(clr_ovr), .bus(bus_b),
    .busy(busy_v[1]), .overrun(ovr_v[1]), .dbg_state(dbg_v[1]));

  assign bus_a.adc_sdo = sdo_v[0];
  assign bus_b.adc_sdo = sdo_v[1];
  assign cs_n_v = {bus_b.adc_cs_n, bus_a.adc_cs_n};
  assign sclk_v = {bus_b.adc_sclk, bus_a.adc_sclk};
  assign push_v = {bus_b.pushADC, bus_a.pushADC};
  assign data_v = {bus_b.data, bus_a.data};

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  function automatic void check(input string name, input int lane,
                                input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s lane%0d cyc %0d: actual %0h required %0h", name, lane, cyc, act, req);
    end
  endfunction

  // Reference conversion: the ADC word read as an integer, then stored as a 26-bit two's-complement value.
  function automatic logic [25:0] ref_sample(input int lane, input logic [13:0] w);
    int v;
    if (lane == 0) v = int'(w) - 8192;
    else           v = (int'(w) >= 8192) ? int'(w) - 16384 : int'(w);
    return 26'(v);
  endfunction

  // Reference model: en-high cycle count, accepted frame windows, overrun flag, and the ADC pin model.
  int          en_cnt[2]    = '{0, 0};
  int          fs[2]        = '{0, 0};
  int          fe[2]        = '{-1, -1};
  int          nfr[2]       = '{0, 0};
  int          idx[2]       = '{0, 0};
  int          sclk_cnt[2]  = '{0, 0};
  logic        ovr_m[2]     = '{1'b0, 1'b0};
  logic        prev_cs[2]   = '{1'b1, 1'b1};
  logic        prev_sclk[2] = '{1'b1, 1'b1};
  logic [13:0] pend[2]      = '{14'h0, 14'h0};
  logic [13:0] cur_w[2]     = '{14'h0, 14'h0};
  logic [13:0] dir_w[6]     = '{14'h2ABC, 14'h3FFF, 14'h0000, 14'h2000, 14'h1FFF, 14'h0001};

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int l = 0; l < 2; l++) begin
        int          per;
        logic        in_win, drop;
        logic [13:0] w;
        exp_t        e;
        per    = (l == 0) ? PER0 : PER1;
        in_win = (cyc >= fs[l]) && (cyc <= fe[l]);
        check("busy", l, busy_v[l], in_win);
        check("dbg_state_busy", l, dbg_v[l] != 2'd0, in_win);
        check("cs_n", l, cs_n_v[l], !((cyc >= fs[l]) && (cyc < fe[l])));
        check("overrun", l, ovr_v[l], ovr_m[l]);
        if (cs_n_v[l]) check("sclk_idle", l, sclk_v[l], 1);
        if (cyc == fe[l]) check("sclk_rises", l, sclk_cnt[l], N_BITS);

        if (prev_cs[l] && !cs_n_v[l]) begin
          cur_w[l]    = pend[l];
          idx[l]      = N_BITS - 1;
          sclk_cnt[l] = 0;
        end else if (!cs_n_v[l]) begin
          if (!prev_sclk[l] && sclk_v[l]) sclk_cnt[l]++;
          if (prev_sclk[l] && !sclk_v[l] && idx[l] >= 0) begin
            sdo_v[l] = cur_w[l][idx[l]];
            idx[l]--;
          end
        end
        prev_cs[l]   = cs_n_v[l];
        prev_sclk[l] = sclk_v[l];

        if (rst) begin
          en_cnt[l] = 0;
          fs[l]     = 0;
          fe[l]     = -1;
          ovr_m[l]  = 1'b0;
          if (l == 0) while (exp_q0.size() > 0 && int'(exp_q0[$].t) > cyc) void'(exp_q0.pop_back());
          else        while (exp_q1.size() > 0 && int'(exp_q1[$].t) > cyc) void'(exp_q1.pop_back());
        end else begin
          drop = 1'b0;
          if (en) begin
            en_cnt[l]++;
            if (en_cnt[l] % per == 0) begin
              if (cyc <= fe[l]) begin
                drop = 1'b1;
              end else begin
                w = (nfr[l] < 6) ? dir_w[nfr[l]] : 14'($urandom_range(0, 16383));
                nfr[l]++;
                pend[l] = w;
                fs[l]   = cyc + 1;
                fe[l]   = cyc + FRAME;
                e.t     = 32'(cyc + FRAME);
                e.d     = ref_sample(l, w);
                if (l == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
              end
            end
          end else begin
            en_cnt[l] = 0;
          end
          if (drop)         ovr_m[l] = 1'b1;
          else if (clr_ovr) ovr_m[l] = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a lane strobes and checks held data otherwise.
  logic [25:0] hold[2] = '{26'h0, 26'h0};

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int l = 0; l < 2; l++) begin
        exp_t e;
        int   qs;
        qs = (l == 0) ? exp_q0.size() : exp_q1.size();
        if (qs > 0) begin
          e = (l == 0) ? exp_q0[0] : exp_q1[0];
          if (int'(e.t) < cyc) begin
            check("push_late", l, cyc, e.t);
            if (l == 0) void'(exp_q0.pop_front());
            else        void'(exp_q1.pop_front());
            qs--;
          end
        end
        if (push_v[l]) begin
          if (qs == 0) begin
            check("push_expected", l, push_v[l], 0);
          end else begin
            if (l == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check("push_time", l, cyc, e.t);
            check("data", l, data_v[l], e.d);
            hold[l] = e.d;
          end
        end else begin
          check("data_hold", l, data_v[l], hold[l]);
        end
        if (rst) hold[l] = 26'h0;
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      clr_ovr = ($urandom_range(0, 79) == 0);
    end
  endtask

  task automatic wait_cs_low(input int lim);
    int k;
    k = 0;
    while (cs_n_v[0] && k < lim) begin
      step(1);
      k++;
    end
    check("wait_cs_low", 0, cs_n_v[0], 0);
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(5);
    en = 1'b1;
    step(1000);

    wait_cs_low(300);
    step(DIV + 2 * DIV * 5 + 2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(600);

    wait_cs_low(300);
    step(DIV + 2 * DIV * 3 + 1);
    en = 1'b0;
    step(400);

    en = 1'b1;
    step(500);
    en = 1'b0;
    step(300);

    check("drain", 0, exp_q0.size(), 0);
    check("drain", 1, exp_q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
